ps2_receiver: RTL

Consumes the synchronized and debounced PS/2 clock and data lines. Detects falling edges of the PS/2 clock and deframes 11-bit PS/2 device-to-host frames: start 0, 8 data bits LSB first, odd parity, stop 1. Delivers each good byte through a holding register with a valid/acknowledge handshake to the keyboard controller. Sits directly downstream of the PS/2 clock and data synchronizer/debouncer instances.

---
 rtl/ps2_receiver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_receiver
// Brief    : PS/2 device-to-host frame deframer with valid/ack holding register.
//            Optional mid-frame watchdog: define PS2_RECEIVER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
   parameter int                      timeoutWidth = 16,
   parameter logic [timeoutWidth-1:0] timeoutValue = 16'd50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2Clock,
   input  logic       ps2Data,
   output logic [7:0] dataOut,
   output logic       dataValid,
   input  logic       dataAck,
   output logic       overrun,
   output logic       parityError,
   output logic       frameError
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t     r_state;
   logic       r_prevClock;
   logic [7:0] r_shift;
   logic [2:0] r_bitCount;
   logic       r_parity;
   logic       w_fall;
   logic       w_timeout;

   assign w_fall = r_prevClock & ~ps2Clock;

`ifdef PS2_RECEIVER_TIMEOUT_EN
   logic [timeoutWidth-1:0] r_timer;

   // Fires on the cycle the counter would step onto timeoutValue.
   assign w_timeout = (r_state != IDLE) && !w_fall &&
                      (r_timer == timeoutValue - 1'b1);
`else
   logic w_unusedParams;

   assign w_timeout      = 1'b0;
   assign w_unusedParams = ^{timeoutWidth, timeoutValue};
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_prevClock <= 1'b1;
         r_shift     <= 8'h00;
         r_bitCount  <= 3'd0;
         r_parity    <= 1'b0;
         dataOut     <= 8'h00;
         dataValid   <= 1'b0;
         overrun     <= 1'b0;
         parityError <= 1'b0;
         frameError  <= 1'b0;
`ifdef PS2_RECEIVER_TIMEOUT_EN
         r_timer     <= '0;
`endif
      end else begin
         r_prevClock <= ps2Clock;
         overrun     <= 1'b0;
         parityError <= 1'b0;
         frameError  <= 1'b0;

         if (dataAck) begin
            dataValid <= 1'b0;
         end

`ifdef PS2_RECEIVER_TIMEOUT_EN
         if (r_state == IDLE || w_fall || w_timeout) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
`endif

         if (w_timeout) begin
            r_state    <= IDLE;
            frameError <= 1'b1;
         end else if (w_fall) begin
            case (r_state)
               IDLE: begin
                  if (!ps2Data) begin
                     r_state    <= DATA;
                     r_bitCount <= 3'd0;
                  end else begin
                     frameError <= 1'b1;
                  end
               end
               DATA: begin
                  r_shift    <= {ps2Data, r_shift[7:1]};
                  r_bitCount <= r_bitCount + 3'd1;
                  if (r_bitCount == 3'd7) begin
                     r_state <= PARITY;
                  end
               end
               PARITY: begin
                  r_parity <= ps2Data;
                  r_state  <= STOP;
               end
               STOP: begin
                  r_state <= IDLE;
                  if (!ps2Data) begin
                     frameError <= 1'b1;
                  end else if (~^{r_shift, r_parity}) begin
                     parityError <= 1'b1;
                  end else begin
                     // A same-cycle ack consumes the old byte, so no overrun.
                     dataOut   <= r_shift;
                     dataValid <= 1'b1;
                     overrun   <= dataValid & ~dataAck;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
